wino_input_tiler: RTL and testbench
===================================

Name: wino_input_tiler

Overview:
- Upstream feeder for the Winograd F(2,3) output-transform stage.
- Accepts a serial row of input samples and forms overlapping 4-sample tiles with stride 2.
- For each tile, produces the data transform x1..x4 = B^T·d and holds the filter transform w1..w4 = G·g, loaded once per row.
- Outputs connect directly to the x1..x4 and w1..w4 inputs of the output-transform stage.

Parameters:
- DW, 32, data width of samples, taps, x and w (signed two's complement).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  tiler can accept a sample.
- in_data  in  DW  signed input sample.
- in_last  in  1  marks the final sample of a row.
- g_load  in  1  single-cycle strobe to load filter taps.
- g0, g1, g2  in  DW each  signed filter taps.
- g_drop  out  1  one-cycle pulse when g_load is ignored.
- out_valid  out  1  tile valid.
- out_ready  in  1  downstream accepts tile.
- x1, x2, x3, x4  out  DW each  transformed data.
- w1, w2, w3, w4  out  DW each  transformed filter.
- out_last  out  1  tile is the last of its row.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, window d0..d3 = 0, count = 0, state FILL.
- Window: 4-entry shift register, d0 oldest. An accepted sample shifts in at d3.
- Transform, DW-bit wrap-around:
  - x1 = d0 - d2
  - x2 = d1 + d2
  - x3 = d2 - d1
  - x4 = d1 - d3
- Outputs x, out_valid and out_last are registered. out_valid rises the cycle after the tile-completing shift.
- Handshake: a sample transfers when in_valid & in_ready.
  - in_ready = 1 only in FILL and PAIR.
  - A tile transfers when out_valid & out_ready.
  - x and out_last stay stable while out_valid=1 and out_ready=0.
- FILL:
  - Counts accepted samples, 0..4. On the 4th sample, go to EMIT.
  - If in_last arrives with count < 4, go to PAD.
- PAIR:
  - Needs 2 new samples. After the 2nd, go to EMIT.
  - If in_last arrives on the 1st, go to PAD.
  - If in_last arrives on the 2nd, go to EMIT with last=1.
- PAD:
  - in_ready = 0. Shifts one zero per cycle until the tile is complete (4 in FILL terms, 2 in PAIR terms), then goes to EMIT with last=1.
- EMIT:
  - Holds until the tile transfers.
  - If last=1, go to FILL with count = 0. Otherwise go to PAIR.
- Tiles per row of N samples: 1 if N ≤ 4, otherwise ceil((N-2)/2).
- Filter transform, registered one cycle after an accepted g_load:
  - w1 = g0, w4 = g2.
  - w2 = (g0+g1+g2) >>> 1 and w3 = (g0-g1+g2) >>> 1, computed at DW+2 bits, arithmetic shift, truncated to DW.
  - w holds between loads.
- g_load acceptance:
  - Accepted only when idle (state FILL, count = 0, out_valid = 0).
  - Otherwise ignored, w unchanged, and g_drop pulses for 1 cycle.
- Simultaneous g_load and first sample in idle: both accepted.
- Reset mid-row: tile discarded, w cleared, and a new row starts from FILL.

Optional Feature:
- Macro: WINO_FILT_ROUND_EN.
- Defined: w2 and w3 use round-half-up, (sum+1) >>> 1. This reduces the halving error later corrected in the output stage.
- Undefined: plain truncating arithmetic shift, as above.

Decomposition:
- Package wino_pkg:
  - DW default.
  - State enum: FILL, PAIR, PAD, EMIT.
  - Functions bt_xform(d0..d3) and g_xform(g0..g2), shared with the output-stage bench model.
- Sub-module wino_filter_xform: filter register, g_load acceptance logic and rounding option.
- The top level holds the window, FSM and output register.

Test Plan:
- Filter: g=(3,5,7) loaded while idle -> w=(3,7,2,7). With WINO_FILT_ROUND_EN -> w=(3,8,3,7).
- Even row: samples 1..6, last on 6, out_ready=1:
  - Tile 1 x=(-2,5,1,-2), out_last=0.
  - Tile 2 x=(-2,9,1,-2), out_last=1.
- Odd row: samples 1..5, last on 5:
  - Tile 2 d=(3,4,5,0) -> x=(-2,9,1,4), out_last=1.
  - in_ready low during the PAD cycle.
- Short row: samples 7,9, last on 9 -> two PAD cycles -> one tile x=(7,9,-9,9), out_last=1.
- Backpressure: out_ready=0 for 3 cycles during a tile -> out_valid held, x stable, in_ready=0. The tile transfers on the cycle out_ready=1.
- g_load during an active row -> g_drop pulses for 1 cycle, w unchanged.
- Async reset asserted during EMIT -> all outputs 0 immediately. After release, a new row tiles correctly.

Source files
------------

// File: rtl/wino_pkg.sv
// ============================================================================
//  Module   : wino_pkg
//  Purpose  : Shared types and the B^T / G transforms for the Winograd F(2,3)
//             input tiler and the output-stage bench model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wino_pkg;

  localparam int DW_DEFAULT = 32;

  typedef logic signed [DW_DEFAULT-1:0] word_t;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAIR = 2'd1,
    ST_PAD  = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  typedef struct packed {
    word_t x1;
    word_t x2;
    word_t x3;
    word_t x4;
  } bt_t;

  typedef struct packed {
    word_t w1;
    word_t w2;
    word_t w3;
    word_t w4;
  } gt_t;

  function automatic bt_t bt_xform(input word_t d0, input word_t d1,
                                   input word_t d2, input word_t d3);
    bt_t r;
    r.x1 = d0 - d2;
    r.x2 = d1 + d2;
    r.x3 = d2 - d1;
    r.x4 = d1 - d3;
    return r;
  endfunction

  // Sums are formed two bits wider so the halving sees the exact value.
  function automatic gt_t g_xform(input word_t g0, input word_t g1,
                                  input word_t g2, input logic rnd);
    logic signed [DW_DEFAULT+1:0] s2;
    logic signed [DW_DEFAULT+1:0] s3;
    logic signed [DW_DEFAULT+1:0] rv;
    gt_t r;
    rv   = signed'({{(DW_DEFAULT+1){1'b0}}, rnd});
    s2   = (DW_DEFAULT+2)'(g0) + (DW_DEFAULT+2)'(g1) + (DW_DEFAULT+2)'(g2) + rv;
    s3   = (DW_DEFAULT+2)'(g0) - (DW_DEFAULT+2)'(g1) + (DW_DEFAULT+2)'(g2) + rv;
    r.w1 = g0;
    r.w2 = DW_DEFAULT'(s2 >>> 1);
    r.w3 = DW_DEFAULT'(s3 >>> 1);
    r.w4 = g2;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wino_filter_xform.sv
// ============================================================================
//  Module   : wino_filter_xform
//  Purpose  : Filter transform register w = G*g, loaded only while the tiler
//             is idle. Define WINO_FILT_ROUND_EN for round-half-up halving.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wino_filter_xform
  import wino_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 idle_i,
  input  logic                 g_load_i,
  input  logic signed [DW-1:0] g0_i,
  input  logic signed [DW-1:0] g1_i,
  input  logic signed [DW-1:0] g2_i,
  output logic                 g_drop_o,
  output logic signed [DW-1:0] w1_o,
  output logic signed [DW-1:0] w2_o,
  output logic signed [DW-1:0] w3_o,
  output logic signed [DW-1:0] w4_o
);

`ifdef WINO_FILT_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  gt_t                 w_xf;
  logic                g_drop_q;
  logic signed [DW-1:0] w1_q, w2_q, w3_q, w4_q;

  always_comb begin
    w_xf = g_xform(word_t'(g0_i), word_t'(g1_i), word_t'(g2_i), RND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_drop_q <= 1'b0;
      w1_q     <= '0;
      w2_q     <= '0;
      w3_q     <= '0;
      w4_q     <= '0;
    end else begin
      g_drop_q <= g_load_i & ~idle_i;
      if (g_load_i && idle_i) begin
        w1_q <= DW'(w_xf.w1);
        w2_q <= DW'(w_xf.w2);
        w3_q <= DW'(w_xf.w3);
        w4_q <= DW'(w_xf.w4);
      end
    end
  end

  assign g_drop_o = g_drop_q;
  assign w1_o     = w1_q;
  assign w2_o     = w2_q;
  assign w3_o     = w3_q;
  assign w4_o     = w4_q;

endmodule

`default_nettype wire

// File: rtl/wino_input_tiler.sv
// ============================================================================
//  Module   : wino_input_tiler
//  Purpose  : Forms stride-2 overlapping 4-sample tiles from a serial row and
//             emits x = B^T*d with the held filter transform w. Optional
//             macro WINO_FILT_ROUND_EN selects rounded filter halving.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wino_input_tiler
  import wino_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_last,
  input  logic                 g_load,
  input  logic signed [DW-1:0] g0,
  input  logic signed [DW-1:0] g1,
  input  logic signed [DW-1:0] g2,
  output logic                 g_drop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x1,
  output logic signed [DW-1:0] x2,
  output logic signed [DW-1:0] x3,
  output logic signed [DW-1:0] x4,
  output logic signed [DW-1:0] w1,
  output logic signed [DW-1:0] w2,
  output logic signed [DW-1:0] w3,
  output logic signed [DW-1:0] w4,
  output logic                 out_last
);

  state_t               state_q;
  logic [2:0]           cnt_q;
  logic                 last_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic signed [DW-1:0] d0_q, d1_q, d2_q, d3_q;
  logic signed [DW-1:0] x1_q, x2_q, x3_q, x4_q;

  logic                 w_idle;
  logic                 w_shift;
  logic signed [DW-1:0] w_din;
  bt_t                  w_bt;

  assign in_ready = (state_q == ST_FILL) || (state_q == ST_PAIR);
  assign w_idle   = (state_q == ST_FILL) && (cnt_q == 3'd0) && !out_valid_q;
  assign w_shift  = (state_q == ST_PAD) || (in_valid && in_ready);
  assign w_din    = (state_q == ST_PAD) ? '0 : in_data;

  always_comb begin
    w_bt = bt_xform(word_t'(d0_q), word_t'(d1_q), word_t'(d2_q), word_t'(d3_q));
  end

  // cnt_q tracks window fill toward 4; a PAIR tile re-enters with 2 samples kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= 3'd0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      x4_q        <= '0;
    end else begin
      if (w_shift) begin
        d0_q  <= d1_q;
        d1_q  <= d2_q;
        d2_q  <= d3_q;
        d3_q  <= w_din;
        cnt_q <= cnt_q + 3'd1;
      end
      case (state_q)
        ST_FILL, ST_PAIR: begin
          if (w_shift) begin
            if (cnt_q == 3'd3) begin
              state_q <= ST_EMIT;
              last_q  <= in_last;
            end else if (in_last) begin
              state_q <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (cnt_q == 3'd3) begin
            state_q <= ST_EMIT;
            last_q  <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_last_q  <= last_q;
            x1_q        <= DW'(w_bt.x1);
            x2_q        <= DW'(w_bt.x2);
            x3_q        <= DW'(w_bt.x3);
            x4_q        <= DW'(w_bt.x4);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_q) begin
              state_q <= ST_FILL;
              cnt_q   <= 3'd0;
            end else begin
              state_q <= ST_PAIR;
              cnt_q   <= 3'd2;
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign x3        = x3_q;
  assign x4        = x4_q;

  wino_filter_xform #(
    .DW (DW)
  ) u_filt (
    .clk      (clk),
    .rst      (rst),
    .idle_i   (w_idle),
    .g_load_i (g_load),
    .g0_i     (g0),
    .g1_i     (g1),
    .g2_i     (g2),
    .g_drop_o (g_drop),
    .w1_o     (w1),
    .w2_o     (w2),
    .w3_o     (w3),
    .w4_o     (w4)
  );

endmodule

`default_nettype wire

// File: tb/tb_wino_input_tiler.sv
// ============================================================================
//  Module   : tb_wino_input_tiler
//  Purpose  : Self-checking bench for wino_input_tiler against a row-level
//             tile model and an arithmetic filter model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wino_input_tiler;

  localparam int DW = 32;
  typedef logic signed [DW-1:0] sw_t;
  typedef struct packed {
    sw_t  a;
    sw_t  b;
    sw_t  c;
    sw_t  d;
    logic last;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, g_load = 1'b0, out_ready = 1'b1;
  logic in_ready, g_drop, out_valid, out_last;
  sw_t  in_data = '0, g0 = '0, g1 = '0, g2 = '0;
  sw_t  x1, x2, x3, x4, w1, w2, w3, w4;

  always #5 clk = ~clk;

  wino_input_tiler #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .g_load(g_load),
    .g0(g0), .g1(g1), .g2(g2), .g_drop(g_drop),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .out_last(out_last)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    bp_mode = 0;
  tile_t exp_q[$];
  sw_t   row[$];
  sw_t   wm1 = '0, wm2 = '0, wm3 = '0, wm4 = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_gload(input sw_t a, input sw_t b, input sw_t c);
    longint s2, s3, r;
`ifdef WINO_FILT_ROUND_EN
    r = 1;
`else
    r = 0;
`endif
    s2  = longint'(a) + longint'(b) + longint'(c) + r;
    s3  = longint'(a) - longint'(b) + longint'(c) + r;
    wm1 = a;
    wm2 = sw_t'(s2 >>> 1);
    wm3 = sw_t'(s3 >>> 1);
    wm4 = c;
  endtask

  // Row of N samples: zero-pad to 4 (short row) or to even length, then one tile per stride of 2.
  task automatic model_row(input sw_t s[$]);
    sw_t   p[$];
    int    len;
    tile_t t;
    p   = s;
    len = (s.size() <= 4) ? 4 : s.size() + (s.size() % 2);
    while (p.size() < len) p.push_back('0);
    for (int k = 0; 2*k + 3 < len; k++) begin
      t.a    = p[2*k]   - p[2*k+2];
      t.b    = p[2*k+1] + p[2*k+2];
      t.c    = p[2*k+2] - p[2*k+1];
      t.d    = p[2*k+1] - p[2*k+3];
      t.last = (2*k + 3 == len - 1);
      exp_q.push_back(t);
    end
  endtask

  task automatic row_seq(input int start, input int n, input int step);
    row.delete();
    for (int i = 0; i < n; i++) row.push_back(sw_t'(start + i*step));
  endtask

  task automatic check_w(input string tag);
    check_eq({tag, "_w1"}, w1, wm1);
    check_eq({tag, "_w2"}, w2, wm2);
    check_eq({tag, "_w3"}, w3, wm3);
    check_eq({tag, "_w4"}, w4, wm4);
  endtask

  task automatic send_sample(input sw_t v, input logic last);
    int t = 0;
    in_valid = 1'b1; in_data = v; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_eq("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_row(input int max_gap);
    model_row(row);
    foreach (row[i]) begin
      send_sample(row[i], i == row.size() - 1);
      if (i != row.size() - 1)
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    check_eq("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic do_gload(input sw_t a, input sw_t b, input sw_t c, input bit accept);
    g_load = 1'b1; g0 = a; g1 = b; g2 = c;
    @(posedge clk); #1;
    g_load = 1'b0;
    if (accept) model_gload(a, b, c);
    @(negedge clk);
    check_eq("g_drop", g_drop, !accept);
    check_w("gload");
    @(negedge clk);
    check_eq("g_drop_clr", g_drop, 1'b0);
    @(posedge clk); #1;
  endtask

  always begin
    @(posedge clk); #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  initial begin : monitor
    tile_t held, got, e;
    bit    hv;
    hv = 0;
    forever begin
      @(negedge clk);
      got = {x1, x2, x3, x4, out_last};
      if (!rst || !out_valid) begin
        hv = 0;
      end else begin
        if (hv) begin
          check_eq("hold_x1", got.a, held.a);
          check_eq("hold_x2", got.b, held.b);
          check_eq("hold_x3", got.c, held.c);
          check_eq("hold_x4", got.d, held.d);
          check_eq("hold_last", got.last, held.last);
        end
        if (out_ready) begin
          hv = 0;
          if (exp_q.size() == 0) begin
            check_eq("extra_tile_valid", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_eq("x1", got.a, e.a);
            check_eq("x2", got.b, e.b);
            check_eq("x3", got.c, e.c);
            check_eq("x4", got.d, e.d);
            check_eq("out_last", got.last, e.last);
          end
        end else begin
          hv   = 1;
          held = got;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_x1", x1, 0);
    check_eq("rst_x4", x4, 0);
    check_eq("rst_g_drop", g_drop, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_w("rst");
    @(posedge clk); #1;

    do_gload(3, 5, 7, 1);
`ifdef WINO_FILT_ROUND_EN
    check_eq("plan_w2", w2, 8);
    check_eq("plan_w3", w3, 3);
`else
    check_eq("plan_w2", w2, 7);
    check_eq("plan_w3", w3, 2);
`endif

    row_seq(1, 6, 1); send_row(0); drain();

    row_seq(1, 5, 1); send_row(0);
    @(negedge clk); check_eq("pad_in_ready", in_ready, 1'b0);
    drain();

    row_seq(7, 2, 2); send_row(0);
    @(negedge clk); check_eq("pad1_in_ready", in_ready, 1'b0);
    @(negedge clk); check_eq("pad2_in_ready", in_ready, 1'b0);
    drain();

    bp_mode = 2;
    row_seq(10, 4, 10); send_row(0);
    wait_valid();
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_in_ready", in_ready, 1'b0);
    end
    bp_mode = 0;
    drain();
    @(negedge clk); check_eq("bp_after_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    row_seq(11, 7, 1);
    model_row(row);
    send_sample(row[0], 1'b0);
    send_sample(row[1], 1'b0);
    do_gload(100, 200, 300, 0);
    for (int i = 2; i < row.size(); i++) send_sample(row[i], i == row.size() - 1);
    drain();

    row_seq(-3, 3, 4);
    model_row(row);
    g_load = 1'b1; g0 = -8; g1 = 6; g2 = 1;
    model_gload(-8, 6, 1);
    send_sample(row[0], 1'b0);
    g_load = 1'b0;
    send_sample(row[1], 1'b0);
    send_sample(row[2], 1'b1);
    drain();
    check_w("simul");

    bp_mode = 1;
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 11);
      row.delete();
      for (int i = 0; i < n; i++) row.push_back(sw_t'($urandom));
      send_row(2);
      drain();
      if ($urandom_range(0, 2) == 0) do_gload(sw_t'($urandom), sw_t'($urandom), sw_t'($urandom), 1);
    end
    bp_mode = 0;

    bp_mode = 2;
    row_seq(5, 4, 1); send_row(0);
    wait_valid();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_out_last", out_last, 1'b0);
    check_eq("arst_x1", x1, 0);
    check_eq("arst_x2", x2, 0);
    check_eq("arst_x3", x3, 0);
    check_eq("arst_x4", x4, 0);
    exp_q.delete();
    wm1 = '0; wm2 = '0; wm3 = '0; wm4 = '0;
    check_w("arst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bp_mode = 0;
    @(posedge clk); #1;
    row_seq(2, 5, 2); send_row(1); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
